// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register: valid/ready handshake, 2-entry skid buffer, flush.
// Optional perf counters (stall_cnt, flush_cnt) when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage_reg #(
    parameter int XLEN = 32,
    parameter int PC_W = 8,
    parameter int WB_W = 2,
    parameter int M_W  = 3,
    parameter int EX_W = 4
`ifdef ID_EX_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WB_W-1:0] in_wb,
    input  logic [M_W-1:0]  in_m,
    input  logic [EX_W-1:0] in_ex,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_reg1,
    input  logic [XLEN-1:0] in_reg2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_shamt,
    input  logic [4:0]      in_rt,
    input  logic [4:0]      in_rd,
    output logic [WB_W-1:0] out_wb,
    output logic [M_W-1:0]  out_m,
    output logic [EX_W-1:0] out_ex,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_reg1,
    output logic [XLEN-1:0] out_reg2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_shamt,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic            out_valid,
    input  logic            out_ready
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int PW = WB_W + M_W + EX_W + PC_W + 32 + 3 * XLEN + 15;

    logic [PW-1:0]   in_word;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic            main_v_q, main_v_d;
    logic            skid_v_q, skid_v_d;
    logic            rdy_q, rdy_d;
    logic            accept, retire;
    logic [WB_W-1:0] o_wb;
    logic [M_W-1:0]  o_m;
    logic [EX_W-1:0] o_ex;

    assign in_word = {in_wb, in_m, in_ex, in_pc, in_instr, in_reg1,
                      in_reg2, in_imm, in_shamt, in_rt, in_rd};

    assign accept = in_valid & rdy_q;
    assign retire = main_v_q & out_ready;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            // in_ready is low here, so nothing can be accepted this cycle
            if (retire) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (accept && (!main_v_q || retire)) begin
            main_d   = in_word;
            main_v_d = 1'b1;
        end else if (accept) begin
            skid_d   = in_word;
            skid_v_d = 1'b1;
        end else if (retire) begin
            main_v_d = 1'b0;
        end
        rdy_d = !skid_v_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= rdy_d;
        end
    end

    assign {o_wb, o_m, o_ex, out_pc, out_instr, out_reg1,
            out_reg2, out_imm, out_shamt, out_rt, out_rd} = main_q;

    assign out_wb    = main_v_q ? o_wb : '0;
    assign out_m     = main_v_q ? o_m  : '0;
    assign out_ex    = main_v_q ? o_ex : '0;
    assign out_valid = main_v_q;
    assign in_ready  = rdy_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate rather than wrap
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_v_q && !out_ready && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && (main_v_q || skid_v_q) && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg against a 2-deep queue model.
// Perf counter checks are active when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage_reg;

    localparam int W  = 160;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_wb = '0;
    logic [2:0]  in_m = '0;
    logic [3:0]  in_ex = '0;
    logic [7:0]  in_pc = '0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_reg1 = '0;
    logic [31:0] in_reg2 = '0;
    logic [31:0] in_imm = '0;
    logic [4:0]  in_shamt = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [1:0]  out_wb;
    logic [2:0]  out_m;
    logic [3:0]  out_ex;
    logic [7:0]  out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_reg1;
    logic [31:0] out_reg2;
    logic [31:0] out_imm;
    logic [4:0]  out_shamt;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage_reg #(
`ifdef ID_EX_PERF_CNT_EN
        .CNT_W(CW),
`endif
        .XLEN(32)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb(in_wb), .in_m(in_m), .in_ex(in_ex),
        .in_pc(in_pc), .in_instr(in_instr),
        .in_reg1(in_reg1), .in_reg2(in_reg2), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_rt(in_rt), .in_rd(in_rd),
        .out_wb(out_wb), .out_m(out_m), .out_ex(out_ex),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm),
        .out_shamt(out_shamt), .out_rt(out_rt), .out_rd(out_rd),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q[$];
    int           m_stall = 0;
    int           m_flush = 0;
    int           cmax = (1 << CW) - 1;

    function automatic logic [W-1:0] out_word();
        return {out_wb, out_m, out_ex, out_pc, out_instr, out_reg1,
                out_reg2, out_imm, out_shamt, out_rt, out_rd};
    endfunction

    function automatic logic [W-1:0] cur_in();
        return {in_wb, in_m, in_ex, in_pc, in_instr, in_reg1,
                in_reg2, in_imm, in_shamt, in_rt, in_rd};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare();
        chk("out_valid", W'(out_valid), W'(q.size() > 0));
        chk("in_ready", W'(in_ready), W'(q.size() < 2));
        if (q.size() > 0) chk("payload", out_word(), q[0]);
        else chk("bubble_ctrl", W'({out_wb, out_m, out_ex}), '0);
`ifdef ID_EX_PERF_CNT_EN
        chk("stall_cnt", W'(stall_cnt), W'(m_stall));
        chk("flush_cnt", W'(flush_cnt), W'(m_flush));
`endif
    endtask

    // One clock: drive at negedge, advance model, check at next negedge
    task automatic cyc(input bit iv, input bit ordy, input bit fl,
                       input logic [7:0] pc);
        bit push, pop;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_pc     = pc;
        in_wb     = 2'($urandom);
        in_m      = 3'($urandom);
        in_ex     = iv ? 4'($urandom) : 4'hF;
        in_instr  = $urandom;
        in_reg1   = $urandom;
        in_reg2   = $urandom;
        in_imm    = $urandom;
        in_shamt  = 5'($urandom);
        in_rt     = 5'($urandom);
        in_rd     = 5'($urandom);
        pop  = (q.size() > 0) && ordy;
        push = iv && (q.size() < 2);
        if (q.size() > 0 && !ordy && m_stall < cmax) m_stall++;
        if (fl && q.size() > 0 && m_flush < cmax) m_flush++;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(cur_in());
        end
        @(negedge clk);
        compare();
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_word", out_word(), '0);
        chk("rst_valid", W'(out_valid), '0);
        chk("rst_ready", W'(in_ready), W'(1));
        q.delete();
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Load a word so the asynchronous clear has something to clear
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        compare();
        cyc(1, 0, 0, 8'h5A);
        cyc(1, 0, 0, 8'h5B);
        mid_reset();
        compare();

        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 8'h10 + 8'(i));
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);

        cyc(1, 0, 0, 8'h20);
        cyc(1, 0, 0, 8'h21);
        cyc(1, 0, 0, 8'h22);
        chk("held_pc", W'(out_pc), W'(8'h20));
        cyc(1, 1, 0, 8'h22);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);

        cyc(1, 0, 0, 8'h30);
        cyc(1, 0, 0, 8'h31);
        cyc(1, 0, 1, 8'h32);
        chk("flush_ex", W'(out_ex), '0);
        cyc(0, 1, 0, 8'h00);

        mid_reset();
        cyc(1, 0, 0, 8'h40);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 1, 8'h00);

        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 19) == 0), 8'($urandom));

        mid_reset();
        compare();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
